// File: rtl/vec_result_writeback.sv
// vec_result_writeback: captures one vector ALU result and serialises its lanes
// into 16-bit data-memory writes, keeping a sticky OR of the stored lanes' flags.
module vec_result_writeback #(
    parameter int LANES = 16,
    parameter int DW    = 16,
    parameter int FW    = 4,
    parameter int AW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_data,
    input  logic [LANES*FW-1:0] in_flags,
    input  logic                in_scalar,
    input  logic [AW-1:0]       in_base_addr,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic                mem_ready,
    output logic                busy,
    output logic                done,
    input  logic                clear_flags,
    output logic [FW-1:0]       flags_sticky
);
    localparam int IW = LANES > 1 ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, STORE, DONE} state_t;
    state_t state, state_nx;

    logic [LANES*DW-1:0] data_q;
    logic [AW-1:0]       base_q;
    logic [IW-1:0]       idx, last;
    logic [FW-1:0]       flags_or;
    logic                accept;

    assign accept    = in_valid && in_ready;
    assign in_ready  = state == IDLE;
    assign busy      = state == STORE;
    assign done      = state == DONE;
    assign mem_we    = busy;
    assign mem_addr  = busy ? base_q + AW'(idx) : '0;
    assign mem_wdata = busy ? data_q[DW*idx +: DW] : '0;

    // Scalar results only contribute lane 0 flags, matching what gets stored.
    always_comb begin
        flags_or = in_flags[FW-1:0];
        if (!in_scalar)
            for (int i = 1; i < LANES; i++) flags_or |= in_flags[FW*i +: FW];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? STORE : IDLE;
            STORE:   state_nx = (mem_ready && idx == last) ? DONE : STORE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= '0;
            base_q       <= '0;
            idx          <= '0;
            last         <= '0;
            flags_sticky <= '0;
        end else begin
            if (accept) begin
                data_q <= in_data;
                base_q <= in_base_addr;
                idx    <= '0;
                last   <= in_scalar ? '0 : IW'(LANES - 1);
            end else if (busy && mem_ready && idx != last) begin
                idx <= idx + 1'b1;
            end
            flags_sticky <= (clear_flags ? '0 : flags_sticky) | (accept ? flags_or : '0);
        end
    end
endmodule

// File: tb/tb_vec_result_writeback.sv
// tb_vec_result_writeback: randomized and directed checks of vec_result_writeback
// against a transaction-level queue model of the expected memory writes.
module tb_vec_result_writeback;
    logic         clk = 0, rst_n = 0;
    logic         in_valid = 0, in_ready, in_scalar = 0;
    logic [255:0] in_data = '0;
    logic [63:0]  in_flags = '0;
    logic [15:0]  in_base_addr = '0;
    logic         mem_we, mem_ready = 1, busy, done, clear_flags = 0;
    logic [15:0]  mem_addr, mem_wdata;
    logic [3:0]   flags_sticky;

    vec_result_writeback dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_flags(in_flags), .in_scalar(in_scalar),
        .in_base_addr(in_base_addr), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done),
        .clear_flags(clear_flags), .flags_sticky(flags_sticky)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wlog[$];
    logic        m_done = 0;
    logic [3:0]  m_sticky = 0;
    time         acc_neg = 0, done_t = 0;
    logic        rnd_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: outputs follow from the queue of writes still owed to memory.
    always @(negedge clk) begin
        logic idle, acc, nd;
        logic [3:0] fo;
        if (!rst_n) begin
            exp_q.delete();
            m_done = 0;
            m_sticky = 0;
        end
        idle = exp_q.size() == 0 && !m_done;
        chk("mem_we", mem_we, exp_q.size() > 0);
        chk("busy", busy, exp_q.size() > 0);
        chk("done", done, m_done);
        chk("in_ready", in_ready, idle);
        chk("flags_sticky", flags_sticky, m_sticky);
        if (exp_q.size() > 0) chk("addr_data", {mem_addr, mem_wdata}, exp_q[0]);
        if (rst_n) begin
            if (mem_we && mem_ready) wlog.push_back({mem_addr, mem_wdata});
            if (done) done_t = $time;
            acc = in_valid && idle;
            nd = 0;
            if (exp_q.size() > 0 && mem_ready) begin
                void'(exp_q.pop_front());
                nd = exp_q.size() == 0;
            end
            fo = 0;
            if (acc) begin
                acc_neg = $time;
                for (int i = 0; i < (in_scalar ? 1 : 16); i++) begin
                    fo |= in_flags[4*i +: 4];
                    exp_q.push_back({16'(in_base_addr + 16'(i)), in_data[16*i +: 16]});
                end
            end
            m_sticky = (clear_flags ? 4'b0 : m_sticky) | fo;
            m_done = nd;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rnd_en) begin
            mem_ready = $urandom_range(3) != 0;
            clear_flags = $urandom_range(7) == 0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [255:0] d, input logic [63:0] f, input logic s,
                        input logic [15:0] b, input logic clr);
        int n = 0;
        in_valid = 1; in_data = d; in_flags = f; in_scalar = s; in_base_addr = b;
        clear_flags = clr;
        while (!in_ready && n < 200) begin tick(); n++; end
        if (!in_ready) chk("send_timeout", 0, 1);
        tick();
        in_valid = 0; clear_flags = 0;
        in_data = {8{$urandom}}; in_flags = {2{$urandom}}; in_base_addr = 16'($urandom);
        in_scalar = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 400) begin tick(); n++; end
        if (!in_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_addr(input logic [15:0] a);
        int n = 0;
        while (!(mem_we && mem_addr == a) && n < 100) begin tick(); n++; end
        chk("wait_addr", mem_addr, a);
    endtask

    function automatic logic [255:0] ramp();
        logic [255:0] d;
        for (int i = 0; i < 16; i++) d[16*i +: 16] = 16'(16'h0100 * i + 16'h0040);
        return d;
    endfunction

    initial begin
        logic [255:0] d;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_sticky", flags_sticky, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        tick();

        wlog.delete(); done_t = 0;
        send(ramp(), 0, 0, 16'h0010, 0);
        wait_idle();
        chk("vec_count", wlog.size(), 16);
        chk("vec_first", wlog[0], 32'h0010_0040);
        chk("vec_last", wlog[15], 32'h001F_0F40);
        chk("vec_done_cyc", (done_t - acc_neg) / 10, 17);

        wlog.delete(); done_t = 0;
        d = '1; d[15:0] = 16'hFE80;
        send(d, 0, 1, 16'h0200, 0);
        wait_idle();
        chk("sc_count", wlog.size(), 1);
        chk("sc_write", wlog[0], 32'h0200_FE80);
        chk("sc_done_cyc", (done_t - acc_neg) / 10, 2);

        wlog.delete(); done_t = 0;
        send(ramp(), 0, 0, 16'h0010, 0);
        wait_addr(16'h0015);
        mem_ready = 0; in_valid = 1;
        repeat (3) tick();
        mem_ready = 1; in_valid = 0;
        wait_idle();
        chk("bp_count", wlog.size(), 16);
        chk("bp_lane5", wlog[5], 32'h0015_0540);
        chk("bp_done_cyc", (done_t - acc_neg) / 10, 20);

        wlog.delete();
        send({8{$urandom}}, 64'h0000_0000_0000_2000, 0, 16'hFFF8, 1);
        chk("wrap_sticky", flags_sticky, 4'b0010);
        wait_idle();
        chk("wrap_a7", wlog[7][31:16], 16'hFFFF);
        chk("wrap_a8", wlog[8][31:16], 16'h0000);
        chk("wrap_a15", wlog[15][31:16], 16'h0007);

        send({8{$urandom}}, 64'h0000_0000_0000_1008, 1, 16'h0300, 0);
        chk("sc_sticky_or", flags_sticky, 4'b1010);
        wait_idle();
        send({8{$urandom}}, 64'h0000_0000_0000_1114, 1, 16'h0400, 1);
        chk("clr_capture", flags_sticky, 4'b0100);
        wait_idle();

        send({8{$urandom}}, 64'hFFFF_FFFF_FFFF_FFFF, 0, 16'h1000, 0);
        wait_addr(16'h1007);
        rst_n = 0;
        #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sticky", flags_sticky, 0);
        tick();
        rst_n = 1;
        tick();
        chk("post_rst_ready", in_ready, 1);
        wlog.delete(); done_t = 0;
        send(ramp(), 0, 1, 16'h0050, 0);
        wait_idle();
        chk("post_rst_write", wlog.size() == 1 ? wlog[0] : 32'hDEAD_BEEF, 32'h0050_0040);
        chk("post_rst_done", (done_t - acc_neg) / 10, 2);

        rnd_en = 1;
        for (int t = 0; t < 40; t++)
            send({8{$urandom}}, {$urandom, $urandom}, $urandom_range(2) == 0,
                 16'($urandom), 0);
        rnd_en = 0;
        mem_ready = 1; clear_flags = 0;
        wait_idle();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
